// File: rtl/seq_detect_n.sv
// seq_detect_n: shifts a DW-bit word out MSB-first and flags a PW-bit pattern.
// Define CLK_DIV_EN to step one bit every DIV clk cycles instead of every cycle.
module seq_detect_n #(
    parameter int DW  = 8,
    parameter int PW  = 4,
    parameter int CW  = 8,
    parameter int DIV = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic [DW-1:0] din,
    input  logic [PW-1:0] pattern,
    input  logic          overlap,
    output logic          x,
    output logic          res,
    output logic          flag,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done
);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int VW = $clog2(PW);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
    localparam logic [VW-1:0] FULL = VW'(PW - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DW-1:0] r_data;
    logic [PW-1:0] r_pat;
    logic          r_ovl;
    logic [PW-2:0] r_hist;
    logic [VW-1:0] r_vcnt;
    logic [BW-1:0] r_bitcnt;
    logic          r_x;
    logic          r_res;
    logic          r_flag;
    logic [CW-1:0] r_count;
    logic          r_busy;
    logic          r_done;

    logic          w_tick;
    logic          w_xnew;
    logic          w_hit;
    logic          w_last;
    logic [PW-1:0] w_win;

`ifdef CLK_DIV_EN
    localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DVW-1:0] DIV_TOP = DVW'(DIV - 1);

    logic [DVW-1:0] r_presc;

    always_ff @(posedge clk) begin
        if (!rst || set || r_state != SHIFT || r_presc == DIV_TOP) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_state == SHIFT) && (r_presc == DIV_TOP);
`else
    // DIV only matters with the prescaler; here every SHIFT cycle is a tick
    assign w_tick = (r_state == SHIFT) && (DIV != 0);
`endif

    assign w_xnew = r_data[DW-1];
    assign w_win  = {r_hist, w_xnew};
    assign w_last = (r_bitcnt == LAST_BIT);
    assign w_hit  = w_tick && (r_vcnt == FULL) && (w_win == r_pat);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (set) begin
            w_state_nxt = SHIFT;
        end else begin
            case (r_state)
                SHIFT: begin
                    if (w_tick && w_last) begin
                        w_state_nxt = DONE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data   <= '0;
            r_pat    <= '0;
            r_ovl    <= 1'b0;
            r_hist   <= '0;
            r_vcnt   <= '0;
            r_bitcnt <= '0;
            r_x      <= 1'b0;
            r_res    <= 1'b0;
            r_flag   <= 1'b0;
            r_count  <= '0;
        end else if (set) begin
            r_data   <= din;
            r_pat    <= pattern;
            r_ovl    <= overlap;
            r_hist   <= '0;
            r_vcnt   <= '0;
            r_bitcnt <= '0;
            r_res    <= 1'b0;
        end else begin
            r_res <= w_hit;
            if (w_tick) begin
                r_x      <= w_xnew;
                r_data   <= r_data << 1;
                r_bitcnt <= r_bitcnt + 1'b1;
                r_hist   <= w_win[PW-2:0];
                // non-overlap: a match consumes its bits, next one needs PW fresh
                if (w_hit && !r_ovl) begin
                    r_vcnt <= '0;
                end else if (r_vcnt != FULL) begin
                    r_vcnt <= r_vcnt + 1'b1;
                end
            end
            if (w_hit) begin
                r_flag <= 1'b1;
                if (r_count != '1) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == SHIFT);
            r_done <= (w_state_nxt == DONE);
        end
    end

    assign x     = r_x;
    assign res   = r_res;
    assign flag  = r_flag;
    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_seq_detect_n.sv
// tb_seq_detect_n: frame-level reference model plus directed lab scenarios.
// A second instance with PW=2, CW=2 covers counter saturation.
module tb_seq_detect_n;
    localparam int DW = 8;
    localparam int PW = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          set;
    logic [DW-1:0] din;
    logic [PW-1:0] pattern;
    logic          overlap;
    logic          x;
    logic          res;
    logic          flag;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;

    logic          set2;
    logic [7:0]    din2;
    logic [1:0]    pat2;
    logic          ovl2;
    logic          x2;
    logic          res2;
    logic          flag2;
    logic [1:0]    count2;
    logic          busy2;
    logic          done2;

    int ntests = 0;
    int nfail  = 0;
    int np     = 0;
    int np2    = 0;

    logic          m_valid = 1'b0;
    logic [DW-1:0] m_bits;
    logic [DW-1:0] m_hits;
    int            m_k;
    logic          e_x;
    logic          e_res;
    logic          e_flag;
    logic [CW-1:0] e_count;
    logic          e_busy;
    logic          e_done;

    seq_detect_n #(.DW(DW), .PW(PW), .CW(CW), .DIV(1)) u_dut (
        .clk(clk), .rst(rst), .set(set), .din(din),
        .pattern(pattern), .overlap(overlap),
        .x(x), .res(res), .flag(flag), .count(count),
        .busy(busy), .done(done)
    );

    seq_detect_n #(.DW(8), .PW(2), .CW(2), .DIV(1)) u_dut2 (
        .clk(clk), .rst(rst), .set(set2), .din(din2),
        .pattern(pat2), .overlap(ovl2),
        .x(x2), .res(res2), .flag(flag2), .count(count2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i of the frame is din[DW-1-i]; mark every index where a match ends.
    function automatic logic [DW-1:0] calc_hits(
        input logic [DW-1:0] d,
        input logic [PW-1:0] p,
        input logic          ov
    );
        logic [DW-1:0] h;
        logic [PW-1:0] w;
        int            last;
        h = '0;
        last = -1;
        for (int i = PW - 1; i < DW; i++) begin
            w = '0;
            for (int j = i - PW + 1; j <= i; j++) begin
                w = {w[PW-2:0], d[DW-1-j]};
            end
            if (w == p && (ov || (i - PW + 1) > last)) begin
                h[i] = 1'b1;
                last = i;
            end
        end
        return h;
    endfunction

    task automatic model_update();
        if (!rst) begin
            m_valid = 1'b1;
            m_k     = DW;
            e_x     = 1'b0;
            e_res   = 1'b0;
            e_flag  = 1'b0;
            e_count = '0;
            e_busy  = 1'b0;
            e_done  = 1'b0;
        end else if (set) begin
            m_bits = din;
            m_hits = calc_hits(din, pattern, overlap);
            m_k    = 0;
            e_res  = 1'b0;
            e_busy = 1'b1;
            e_done = 1'b0;
        end else if (e_busy) begin
            e_x   = m_bits[DW-1-m_k];
            e_res = m_hits[m_k];
            if (e_res) begin
                e_flag = 1'b1;
                if (e_count != '1) e_count = e_count + 1'b1;
            end
            m_k++;
            if (m_k == DW) begin
                e_busy = 1'b0;
                e_done = 1'b1;
            end
        end else begin
            e_res = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("x", 32'(x), 32'(e_x));
        chk("res", 32'(res), 32'(e_res));
        chk("flag", 32'(flag), 32'(e_flag));
        chk("count", 32'(count), 32'(e_count));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        if (res === 1'b1) np++;
        if (res2 === 1'b1) np2++;
        if (m_valid) compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set = 1'b0;
        steps(2);
        rst = 1'b1;
    endtask

    task automatic load(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic ov);
        din = d;
        pattern = p;
        overlap = ov;
        set = 1'b1;
        step();
        set = 1'b0;
    endtask

    initial begin
        int p0;
        int nb;
        rst = 1'b0;
        set = 1'b0;
        din = '0;
        pattern = '0;
        overlap = 1'b0;
        set2 = 1'b0;
        din2 = '0;
        pat2 = '0;
        ovl2 = 1'b0;

        do_reset();
        chk("rst_count", 32'(count), 0);
        chk("rst_count2", 32'(count2), 0);

        // T1: overlap, hits after bits 3 and 6
        p0 = np;
        load(8'b10110110, 4'b1011, 1'b1);
        steps(8);
        chk("t1_pulses", 32'(np - p0), 2);
        chk("t1_count", 32'(count), 2);
        chk("t1_flag", 32'(flag), 1);
        chk("t1_done", 32'(done), 1);

        // T6: reload mid-frame after bits 1,0,1; history must not carry over
        p0 = np;
        load(8'b10100000, 4'b1011, 1'b1);
        steps(3);
        chk("t6_x_before", 32'(x), 1);
        load(8'b10000000, 4'b1011, 1'b1);
        chk("t6_busy", 32'(busy), 1);
        chk("t6_x_held", 32'(x), 1);
        nb = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy) nb++;
        end
        chk("t6_busy_cycles", 32'(nb), 8);
        chk("t6_pulses", 32'(np - p0), 0);
        chk("t6_count", 32'(count), 2);

        // T2: non-overlap, single hit
        do_reset();
        p0 = np;
        load(8'b10110110, 4'b1011, 1'b0);
        steps(8);
        chk("t2_pulses", 32'(np - p0), 1);
        chk("t2_count", 32'(count), 1);

        // T3: all ones
        do_reset();
        p0 = np;
        load(8'hFF, 4'b1111, 1'b1);
        steps(8);
        chk("t3o_pulses", 32'(np - p0), 5);
        chk("t3o_count", 32'(count), 5);
        do_reset();
        p0 = np;
        load(8'hFF, 4'b1111, 1'b0);
        steps(8);
        chk("t3n_pulses", 32'(np - p0), 2);
        chk("t3n_count", 32'(count), 2);

        // T4: PW=2 instance, 7 hits saturate a 2-bit counter
        p0 = np2;
        din2 = 8'hFF;
        pat2 = 2'b11;
        ovl2 = 1'b1;
        set2 = 1'b1;
        step();
        set2 = 1'b0;
        steps(9);
        chk("t4_pulses", 32'(np2 - p0), 7);
        chk("t4_count", 32'(count2), 3);
        chk("t4_flag", 32'(flag2), 1);
        chk("t4_done", 32'(done2), 1);

        // T5: reset after 3 ticks, with a coincident set
        do_reset();
        load(8'b10110110, 4'b1011, 1'b1);
        steps(3);
        rst = 1'b0;
        set = 1'b1;
        step();
        chk("t5_x", 32'(x), 0);
        chk("t5_res", 32'(res), 0);
        chk("t5_flag", 32'(flag), 0);
        chk("t5_count", 32'(count), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        rst = 1'b1;
        set = 1'b0;
        steps(2);
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_idle_done", 32'(done), 0);
        chk("t5_idle_x", 32'(x), 0);

        // Random traffic against the frame model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            set = ($urandom_range(0, 9) == 0);
            din = DW'($urandom);
            pattern = PW'($urandom);
            overlap = 1'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/seq_detect_n.md
Name: seq_detect_n

Overview:
- Parametrised successor to the fixed 4-bit Mealy sequence detectors used in the lab designs.
- Loads a DW-bit parallel word and serialises it MSB-first, one bit per shift tick.
- Detects a runtime-programmable PW-bit pattern in the bit stream, in either overlapping or non-overlapping mode.
- Drives a one-cycle match pulse, a sticky hit flag, a saturating match counter and frame status, so board tops can drive LEDs directly.

Parameters:
- DW, 8: parallel word width, i.e. bits per frame; DW >= PW.
- PW, 4: pattern length in bits; 2 <= PW <= DW.
- CW, 8: match counter width.
- DIV, 50_000_000: shift-tick prescale period in clk cycles. Used only when CLK_DIV_EN is defined; DIV >= 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset.
- set  in  1  load strobe; captures din, pattern and overlap, then starts a frame.
- din  in  DW  parallel data word.
- pattern  in  PW  pattern to detect; pattern[PW-1] is the first bit in time.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- x  out  1  serial bit consumed on the most recent tick (debug/LED).
- res  out  1  match pulse, one clk cycle wide.
- flag  out  1  sticky: 1 after any match since reset.
- count  out  CW  saturating match count since reset.
- busy  out  1  frame in progress (SHIFT state).
- done  out  1  frame fully shifted (DONE state).

Behaviour:
- Reset: when rst==0 at a clk edge, all of the following clear to 0: state=IDLE, data, hist, vcnt, bitcnt, x, res, flag, count, busy, done. Reset has priority over everything else.
- Control FSM, IDLE/SHIFT/DONE:
  - IDLE/DONE --set--> SHIFT.
  - SHIFT --(tick && bitcnt==DW-1)--> DONE.
  - set in any state, including mid-SHIFT, reloads and restarts the frame (SHIFT).
- Load (set==1): data<=din; pat_q<=pattern; ovl_q<=overlap; bitcnt, hist, vcnt, res<=0; prescaler<=0. count and flag are kept.
  - set has priority over a coincident tick; no bit is consumed that cycle.
  - pattern and overlap are used only as latched, so changes mid-frame have no effect.
- Shift tick (SHIFT only, every clk without CLK_DIV_EN):
  - x<=data[DW-1]; data<=data<<1; bitcnt++.
  - hist (PW-1 bits) <= {hist[PW-3:0], x_new}; for PW==2, hist is the single bit x_new.
  - vcnt counts valid history bits and saturates at PW-1.
- Mealy hit, combinational on the tick: hit = (vcnt==PW-1) && ({hist, x_new}==pat_q).
- Match outputs:
  - res<=hit, registered: high for exactly the one clk cycle after the tick, and 0 on every other cycle.
  - On hit: flag<=1; count<=count+1, holding at 2^CW-1 once saturated.
  - Non-overlap mode: on hit, vcnt<=0, so the next match needs PW fresh bits. Overlap mode keeps the history.
- Frame boundaries: no match straddles frames, because hist is cleared on load. No ticks occur in IDLE or DONE, and x holds its last value.
- busy=(state==SHIFT), done=(state==DONE), both registered.

Optional Feature:
- Macro: CLK_DIV_EN.
- Defined: an internal prescaler counts 0..DIV-1 in SHIFT; tick is asserted when it equals DIV-1, then it wraps to 0. Gives 1 bit per DIV clk cycles for visible LED stepping on the board. The prescaler clears on reset and set. All logic stays on clk, with no derived clocks.
- Undefined: tick=1 every clk cycle in SHIFT; DIV is ignored.

Test Plan:
- T1: din=8'b10110110, pattern=4'b1011, overlap=1, pulse set -> res pulses after bit indices 3 and 6; count=2, flag=1, done=1 after 8 ticks.
- T2: same stimulus with overlap=0 -> single res after bit 3; count=1.
- T3: din=8'hFF, pattern=4'b1111 -> overlap: 5 pulses, count=5. Non-overlap (fresh reset): 2 pulses (after bits 3 and 7), count=2.
- T4: PW=2, CW=2, pattern=2'b11, din=8'hFF, overlap=1 -> 7 hits; count saturates at 3, flag=1, res pulses 7 times.
- T5: rst=0 after 3 ticks of T1 -> next cycle every output is 0 and state is IDLE. set at the same edge as rst=0 is ignored.
- T6: mid-frame reload: din=8'b10100000, set after bits 1,0,1; then din=8'b10000000, pattern=4'b1011 -> no match (history cleared), count unchanged, busy restarts. Also check that set coincident with a tick consumes no bit.
